adder_io_ctrl: RTL and testbench
================================

// Module: adder_io_ctrl
// PURPOSE
//   Sequencing stage wrapped around the 4-bit combinational ripple adder.
//   Accepts an operand pair over a valid/ready handshake and drives it, held stable, onto the adder inputs.
//   Waits a fixed settle time, then registers the adder's 5-bit sum.
//   Presents the registered sum downstream over a second valid/ready handshake.
//   The adder sits beside this block: add_a/add_b feed it, add_sum comes back.
// PARAMETERS
//   SETTLE_CYCLES  2   cycles add_a/add_b are held before add_sum is captured; legal range 1..15
// PORTS
//   clk        in   1  single clock; all state changes on rising edge
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  upstream operand pair valid
//   in_ready   out  1  block can accept an operand pair
//   in_a       in   4  operand a
//   in_b       in   4  operand b
//   add_a      out  4  registered operand to adder input a
//   add_b      out  4  registered operand to adder input b
//   add_sum    in   5  adder result {carry, sum[3:0]}
//   out_valid  out  1  registered result valid
//   out_ready  in   1  downstream accepts result
//   out_sum    out  5  registered result
//   out_carry  out  1  equals out_sum[4]
//   busy       out  1  high in SETTLE or DONE
// BEHAVIOUR
//   Reset: state=IDLE, add_a=add_b=0, out_sum=0, out_valid=0, settle counter=0.
//     Reset values appear after the first clk edge with rst=1.
//   States and transitions:
//     IDLE:   in_ready=1. On in_valid&in_ready, latch in_a->add_a and in_b->add_b, load cnt=SETTLE_CYCLES-1, go to SETTLE.
//     SETTLE: in_ready=0, add_a/add_b frozen.
//       Each edge with cnt!=0: cnt decrements.
//       Edge with cnt==0: out_sum<=add_sum, out_valid<=1, go to DONE.
//     DONE:   out_valid=1; out_sum is held stable while out_ready=0.
//       On out_valid&out_ready: out_valid<=0, go to IDLE.
//   Latency: accept edge E -> capture edge E+SETTLE_CYCLES -> out_valid high in the following cycle.
//   Throughput: minimum accept-to-accept spacing is SETTLE_CYCLES+2 cycles.
//     in_ready is asserted only in IDLE; there is no skid buffer.
//   Outside IDLE, in_valid, in_a and in_b are ignored and no operand is lost or overwritten.
//   add_a/add_b keep the last accepted operands after DONE; they change only on an accept.
//   add_sum is sampled only on the capture edge; its value at any other time is don't-care.
//   Width: no arithmetic is done here; the 5-bit add_sum is passed through unmodified.
//   rst in any state aborts the operation in the same edge.
//     The pending result is discarded; out_valid is 0 on the next cycle.
//   out_ready while out_valid=0 has no effect.
//   SETTLE_CYCLES outside 1..15 is a configuration error; flag it with an elaboration-time $error.
// CONFIGURATION
//   Macro ADDER_IO_STATS_EN enables statistics.
//   Defined: extra outputs op_count[15:0] and carry_count[15:0].
//     Both reset to 0 and increment on each output handshake; carry_count only when out_sum[4]=1.
//     Both wrap modulo 2^16.
//   Undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//   Package adder_io_pkg holds:
//     - state encoding localparams S_IDLE=2'd0, S_SETTLE=2'd1, S_DONE=2'd2
//     - OPW=4 and SUMW=5
//     - CNTW=4, the settle counter width
//   One sub-module, adder_settle_timer (load/decrement/zero flag), instantiated once.
//   The adder is instantiated by the parent, not inside this block.
// TESTING (bench instantiates this block plus the adder; SETTLE_CYCLES=2 unless stated)
//   1. Accept a=9, b=8 -> out_valid rises 2 cycles after the accept edge; out_sum=5'd17, out_carry=1.
//   2. out_ready=0 for 5 cycles after result 5'd17 -> out_sum/out_valid held; in_ready=0.
//      A concurrent in_valid with a=1, b=1 is not accepted.
//   3. Back-to-back pairs 15+15 then 0+0 with out_ready=1 -> results 5'd30 then 5'd0, in order.
//      Accept spacing is exactly 4 cycles.
//   4. rst asserted in SETTLE (a=7, b=3) -> next cycle: IDLE, in_ready=1, out_valid=0, add_a=add_b=0.
//      No result is ever emitted.
//   5. SETTLE_CYCLES=1, a=4, b=5 -> out_valid in the cycle after the accept edge; out_sum=5'd9, out_carry=0.
//   6. With ADDER_IO_STATS_EN defined: ops 9+8, 2+3, 12+4 -> op_count=3, carry_count=2.

Source files
------------

// File: rtl/adder_io_pkg.sv
// rtl/adder_io_pkg.sv - shared widths and state encoding for the adder IO sequencer
package adder_io_pkg;

  localparam int OPW  = 4;
  localparam int SUMW = 5;
  localparam int CNTW = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

endpackage

// File: rtl/adder_io_if.sv
// rtl/adder_io_if.sv - operand/result handshake bus of the adder IO sequencer
interface adder_io_if;
  import adder_io_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_a;
  logic [OPW-1:0]  in_b;
  logic            out_valid;
  logic            out_ready;
  logic [SUMW-1:0] out_sum;
  logic            out_carry;

  // The sequencer is the slave of this bus; the environment drives operands.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

endinterface

// File: rtl/adder_settle_timer.sv
// rtl/adder_settle_timer.sv - loadable down-counter timing the adder settle window
module adder_settle_timer
  import adder_io_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/adder_io_ctrl.sv
// rtl/adder_io_ctrl.sv - holds operands on an external adder, captures its sum after a settle time
// ADDER_IO_STATS_EN adds op_count/carry_count outputs.
module adder_io_ctrl
  import adder_io_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  adder_io_if.slave       bus,
  output logic [OPW-1:0]  add_a,
  output logic [OPW-1:0]  add_b,
  input  logic [SUMW-1:0] add_sum,
`ifdef ADDER_IO_STATS_EN
  output logic [15:0]     op_count,
  output logic [15:0]     carry_count,
`endif
  output logic            busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("adder_io_ctrl: SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);
  end

  localparam logic [CNTW-1:0] LOAD_VAL = CNTW'(SETTLE_CYCLES - 1);

  logic [1:0]      state;
  logic [SUMW-1:0] sum_q;
  logic            valid_q;
  logic            accept;
  logic            release_res;
  logic            settle_zero;
  logic [CNTW-1:0] settle_cnt;

  assign accept      = (state == S_IDLE) && bus.in_valid;
  assign release_res = valid_q && bus.out_ready;

  adder_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (state == S_SETTLE),
    .cnt      (settle_cnt),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      add_a   <= '0;
      add_b   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            add_a <= bus.in_a;
            add_b <= bus.in_b;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // add_sum is only trusted once the full settle window has elapsed.
          if (settle_zero) begin
            sum_q   <= add_sum;
            valid_q <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (release_res) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADDER_IO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count    <= '0;
      carry_count <= '0;
    end else if (release_res) begin
      op_count <= op_count + 16'd1;
      if (sum_q[SUMW-1]) begin
        carry_count <= carry_count + 16'd1;
      end
    end
  end
`endif

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = sum_q[SUMW-1];
  assign busy          = (state == S_SETTLE) || (state == S_DONE);

endmodule

// File: tb/tb_adder_io_ctrl.sv
// tb/tb_adder_io_ctrl.sv - directed checks of the adder IO sequencer with a behavioural adder beside it
module tb_adder_io_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_io_if bus0 ();
  adder_io_if bus1 ();

  logic [3:0] add_a0, add_b0, add_a1, add_b1;
  logic [4:0] add_sum0, add_sum1;
  logic       busy0, busy1;

  assign add_sum0 = {1'b0, add_a0} + {1'b0, add_b0};
  assign add_sum1 = {1'b0, add_a1} + {1'b0, add_b1};

`ifdef ADDER_IO_STATS_EN
  logic [15:0] op_count0, carry_count0, op_count1, carry_count1;
`endif

  adder_io_ctrl #(.SETTLE_CYCLES(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus0),
    .add_a       (add_a0),
    .add_b       (add_b0),
    .add_sum     (add_sum0),
`ifdef ADDER_IO_STATS_EN
    .op_count    (op_count0),
    .carry_count (carry_count0),
`endif
    .busy        (busy0)
  );

  adder_io_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus1),
    .add_a       (add_a1),
    .add_b       (add_b1),
    .add_sum     (add_sum1),
`ifdef ADDER_IO_STATS_EN
    .op_count    (op_count1),
    .carry_count (carry_count1),
`endif
    .busy        (busy1)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
    logic       carry;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output logic [4:0] sum, output int lat);
    int w;
    w = 0;
    while (!bus0.in_ready && w < 20) begin
      step();
      w++;
    end
    bus0.in_valid = 1'b1;
    bus0.in_a     = a;
    bus0.in_b     = b;
    step();
    bus0.in_valid = 1'b0;
    lat = 0;
    while (!bus0.out_valid && lat < 20) begin
      step();
      lat++;
    end
    sum = bus0.out_sum;
  endtask

  task automatic release_result();
    bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;
  endtask

  initial begin
    logic [4:0] sum;
    int         lat;
    int         acc_cyc[2];
    logic [4:0] res[2];
    int         n_acc, n_res, seen;
    logic       acc, rel;
    logic [4:0] cur;

    vecs[0] = '{a: 4'd9,  b: 4'd8,  sum: 5'd17, carry: 1'b1};
    vecs[1] = '{a: 4'd15, b: 4'd15, sum: 5'd30, carry: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  sum: 5'd0,  carry: 1'b0};
    vecs[3] = '{a: 4'd4,  b: 4'd5,  sum: 5'd9,  carry: 1'b0};
    vecs[4] = '{a: 4'd7,  b: 4'd3,  sum: 5'd10, carry: 1'b0};
    vecs[5] = '{a: 4'd12, b: 4'd4,  sum: 5'd16, carry: 1'b1};
    vecs[6] = '{a: 4'd2,  b: 4'd3,  sum: 5'd5,  carry: 1'b0};

    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b0;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready", bus0.in_ready, 1);
    check("reset_out_valid", bus0.out_valid, 0);
    check("reset_out_sum", bus0.out_sum, 0);
    check("reset_add_a", add_a0, 0);
    check("reset_add_b", add_b0, 0);
    check("reset_busy", busy0, 0);

    // Table: each pair, latency of 2, held operands, and release.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, sum, lat);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("vec%0d_carry", i), bus0.out_carry, vecs[i].carry);
      check($sformatf("vec%0d_add_a", i), add_a0, vecs[i].a);
      check($sformatf("vec%0d_add_b", i), add_b0, vecs[i].b);
      check($sformatf("vec%0d_busy", i), busy0, 1);
      release_result();
      check($sformatf("vec%0d_released", i), bus0.out_valid, 0);
      check($sformatf("vec%0d_idle", i), bus0.in_ready, 1);
    end

    // Backpressure with a competing operand pair offered.
    run_op(4'd9, 4'd8, sum, lat);
    bus0.in_valid = 1'b1;
    bus0.in_a     = 4'd1;
    bus0.in_b     = 4'd1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("hold%0d_out_valid", c), bus0.out_valid, 1);
      check($sformatf("hold%0d_out_sum", c), bus0.out_sum, 17);
      check($sformatf("hold%0d_in_ready", c), bus0.in_ready, 0);
      check($sformatf("hold%0d_add_a", c), add_a0, 9);
    end
    bus0.in_valid = 1'b0;
    release_result();
    check("hold_released", bus0.out_valid, 0);
    check("hold_add_b_kept", add_b0, 8);

    // Back-to-back pairs with the sink always ready.
    n_acc = 0;
    n_res = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    res[0] = '1; res[1] = '1;
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.in_a      = 4'd15;
    bus0.in_b      = 4'd15;
    for (int c = 0; c < 30 && n_res < 2; c++) begin
      acc = bus0.in_ready && bus0.in_valid;
      rel = bus0.out_valid && bus0.out_ready;
      cur = bus0.out_sum;
      step();
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 1) begin
          bus0.in_a = 4'd0;
          bus0.in_b = 4'd0;
        end else begin
          bus0.in_valid = 1'b0;
        end
      end
      if (rel && n_res < 2) begin
        res[n_res] = cur;
        n_res++;
      end
    end
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b0;
    check("b2b_result_count", n_res, 2);
    check("b2b_first", res[0], 30);
    check("b2b_second", res[1], 0);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 4);

    // Reset during SETTLE discards the operation.
    bus0.in_valid = 1'b1;
    bus0.in_a     = 4'd7;
    bus0.in_b     = 4'd3;
    step();
    bus0.in_valid = 1'b0;
    check("abort_in_settle", busy0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", bus0.in_ready, 1);
    check("abort_out_valid", bus0.out_valid, 0);
    check("abort_add_a", add_a0, 0);
    check("abort_add_b", add_b0, 0);
    seen = 0;
    bus0.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus0.out_valid) seen++;
    end
    bus0.out_ready = 1'b0;
    check("abort_no_result", seen, 0);

    // Minimum settle time on the second instance.
    bus1.in_valid = 1'b1;
    bus1.in_a     = 4'd4;
    bus1.in_b     = 4'd5;
    step();
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("settle1_latency", lat, 1);
    check("settle1_sum", bus1.out_sum, 9);
    check("settle1_carry", bus1.out_carry, 0);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    check("settle1_released", bus1.out_valid, 0);

`ifdef ADDER_IO_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stats_reset_ops", op_count0, 0);
    check("stats_reset_carries", carry_count0, 0);
    run_op(4'd9, 4'd8, sum, lat);
    release_result();
    run_op(4'd2, 4'd3, sum, lat);
    release_result();
    run_op(4'd12, 4'd4, sum, lat);
    release_result();
    check("stats_ops", op_count0, 3);
    check("stats_carries", carry_count0, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
